// File: rtl/int_pkg.sv
// Shared definitions for the interrupt controller and its EPC stack.
package int_pkg;
  typedef enum logic [0:0] {
    S_NORM = 1'b0,
    S_WAIT = 1'b1
  } int_state_t;

  localparam int unsigned NUM_IRQ_DEF    = 3;
  localparam logic [31:0] VEC_BASE_DEF   = 32'h0000_0100;
  localparam logic [31:0] VEC_STRIDE_DEF = 32'h0000_0040;
endpackage

// File: rtl/int_epc_stack.sv
// LIFO of saved exception PCs; push wins if push and pop coincide.
module int_epc_stack #(
  parameter int unsigned DEPTH = 3,
  parameter int unsigned WIDTH = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  logic                         pop,
  input  logic [WIDTH-1:0]             push_data,
  output logic [WIDTH-1:0]             top,
  output logic [$clog2(DEPTH+1)-1:0]   depth
);
  localparam int unsigned DW = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
    end else if (push) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        if (depth == DW'(i)) mem[i] <= push_data;
      end
      depth <= depth + DW'(1);
    end else if (pop && depth != '0) begin
      depth <= depth - DW'(1);
    end
  end

  always_comb begin
    top = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (depth == DW'(i + 1)) top = mem[i];
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    !(push && depth == DW'(DEPTH)));
endmodule

// File: rtl/int_controller.sv
// Vectored, nestable interrupt controller: latches request edges, enters
// handlers at a safe ID slot and returns on ERET via the EPC stack.
module int_controller
  import int_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = NUM_IRQ_DEF,
  parameter logic [31:0] VEC_BASE   = VEC_BASE_DEF,
  parameter logic [31:0] VEC_STRIDE = VEC_STRIDE_DEF
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] irq,
  input  logic [31:0]        pc_id,
  input  logic               id_valid,
  input  logic               stall_id,
  input  logic               branch_ex,
  input  logic               eret_id,
  input  logic               halt,
  output logic               flush,
  output logic               pc_redirect,
  output logic [31:0]        pc_target,
  output logic               in_service,
  output logic [NUM_IRQ-1:0] irq_active,
  output logic [NUM_IRQ-1:0] irq_pending,
  output logic               eret_err
);
  localparam int unsigned IW = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1;
  localparam int unsigned PW = $clog2(NUM_IRQ + 1);
  localparam int unsigned DW = $clog2(NUM_IRQ + 1);

  int_state_t        state;
  logic [NUM_IRQ-1:0] irq_d, pending, active;
  logic [NUM_IRQ-1:0] acc_mask, ret_mask;
  logic [PW-1:0]     cur_prio;
  logic [IW-1:0]     cand;
  logic              cand_found, cand_ok, safe;
  logic              accept, do_eret, eret_bad;
  logic [31:0]       epc_top;
  logic [DW-1:0]     depth;

  always_comb begin
    cur_prio = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (active[i]) cur_prio = PW'(i + 1);
    end
  end

  // Only sources strictly above the current service level may preempt.
  always_comb begin
    cand       = '0;
    cand_found = 1'b0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (pending[i] && PW'(i + 1) > cur_prio) begin
        cand       = IW'(i);
        cand_found = 1'b1;
      end
    end
  end

  assign cand_ok = cand_found & ~halt;
  assign safe    = id_valid & ~stall_id & ~branch_ex;

  assign accept   = (state == S_WAIT) & cand_ok & safe;
  assign do_eret  = (state == S_NORM) & ~cand_ok & eret_id & safe & (depth != '0);
  assign eret_bad = (state == S_NORM) & ~cand_ok & eret_id & safe & (depth == '0);

  always_comb begin
    acc_mask = '0;
    ret_mask = '0;
    for (int unsigned i = 0; i < NUM_IRQ; i++) begin
      if (accept && cand == IW'(i)) acc_mask[i] = 1'b1;
      if (do_eret && cur_prio == PW'(i + 1)) ret_mask[i] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_NORM;
      irq_d    <= '0;
      pending  <= '0;
      active   <= '0;
      eret_err <= 1'b0;
    end else begin
      irq_d   <= irq;
      pending <= (pending & ~acc_mask) | (irq & ~irq_d);
      active  <= (active | acc_mask) & ~ret_mask;
      if (eret_bad) eret_err <= 1'b1;
      case (state)
        S_NORM: if (cand_ok) state <= S_WAIT;
        S_WAIT: if (!cand_ok || safe) state <= S_NORM;
        default: state <= S_NORM;
      endcase
    end
  end

  int_epc_stack #(
    .DEPTH (NUM_IRQ),
    .WIDTH (32)
  ) u_epc_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .pop       (do_eret),
    .push_data (pc_id),
    .top       (epc_top),
    .depth     (depth)
  );

  always_comb begin
    flush       = 1'b0;
    pc_redirect = 1'b0;
    pc_target   = '0;
    if (!rst && accept) begin
      flush       = 1'b1;
      pc_redirect = 1'b1;
      pc_target   = VEC_BASE + 32'(cand) * VEC_STRIDE;
    end else if (!rst && do_eret) begin
      flush       = 1'b1;
      pc_redirect = 1'b1;
      pc_target   = epc_top;
    end
  end

  assign in_service  = (depth != '0);
  assign irq_active  = active;
  assign irq_pending = pending;
endmodule

// File: tb/tb_int_controller.sv
// Scenario bench for int_controller: expected redirect targets are queued
// when stimulus is applied and popped when the DUT redirects fetch.
module tb_int_controller;
  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  irq;
  logic [31:0] pc_id;
  logic        id_valid, stall_id, branch_ex, eret_id, halt;
  logic        flush, pc_redirect, in_service, eret_err;
  logic [31:0] pc_target;
  logic [2:0]  irq_active, irq_pending;

  int total = 0;
  int bad   = 0;
  logic [31:0] exp_q [$];

  int_controller #(
    .NUM_IRQ    (3),
    .VEC_BASE   (32'h0000_0100),
    .VEC_STRIDE (32'h0000_0040)
  ) dut (
    .clk(clk), .rst(rst), .irq(irq), .pc_id(pc_id), .id_valid(id_valid),
    .stall_id(stall_id), .branch_ex(branch_ex), .eret_id(eret_id), .halt(halt),
    .flush(flush), .pc_redirect(pc_redirect), .pc_target(pc_target),
    .in_service(in_service), .irq_active(irq_active), .irq_pending(irq_pending),
    .eret_err(eret_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Samples mid-cycle until pc_redirect rises or max cycles elapse.
  task automatic wait_redir(input int max, output bit got, output int n);
    got = 1'b0;
    n   = 0;
    for (int k = 0; k < max; k++) begin
      #1;
      if (pc_redirect === 1'b1) begin
        got = 1'b1;
        n   = k;
        break;
      end
      tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; irq = '0; pc_id = '0; id_valid = 1'b1; stall_id = 1'b0;
    branch_ex = 1'b0; eret_id = 1'b0; halt = 1'b0;
    tick(); tick();
    rst = 1'b0;
    #1;
    total++;
    if ({flush, pc_redirect, pc_target, in_service, irq_active, irq_pending, eret_err} !== '0) begin
      bad++;
      $display("FAIL reset_state: got f=%b r=%b t=%h s=%b a=%b p=%b e=%b want all zero",
               flush, pc_redirect, pc_target, in_service, irq_active, irq_pending, eret_err);
    end
    tick();
  endtask

  task automatic test_single();
    bit got; int n; logic [31:0] e;
    pc_id = 32'h20; irq = 3'b001; exp_q.push_back(32'h100);
    tick();
    total++;
    if (irq_pending !== 3'b001) begin
      bad++; $display("FAIL single_pending: got %b want 001", irq_pending);
    end
    irq = '0;
    wait_redir(5, got, n);
    total++;
    if (!got || n != 1) begin
      bad++; $display("FAIL single_latency: got=%0d cycles=%0d want redirect after 1 more", got, n);
    end
    e = exp_q.pop_front();
    total++;
    if ({flush, pc_redirect, pc_target} !== {2'b11, e}) begin
      bad++; $display("FAIL single_entry: got f=%b r=%b t=%h want 1 1 %h", flush, pc_redirect, pc_target, e);
    end
    tick();
    total++;
    if ({irq_active, irq_pending, in_service} !== {3'b001, 3'b000, 1'b1}) begin
      bad++; $display("FAIL single_active: got a=%b p=%b s=%b want 001 000 1", irq_active, irq_pending, in_service);
    end
    pc_id = 32'h104; eret_id = 1'b1; exp_q.push_back(32'h20);
    #1;
    e = exp_q.pop_front();
    total++;
    if ({flush, pc_redirect, pc_target} !== {2'b11, e}) begin
      bad++; $display("FAIL single_eret: got f=%b r=%b t=%h want 1 1 %h", flush, pc_redirect, pc_target, e);
    end
    tick();
    eret_id = 1'b0;
    #1;
    total++;
    if ({in_service, irq_active, pc_redirect} !== 5'b0) begin
      bad++; $display("FAIL single_exit: got s=%b a=%b r=%b want 0 000 0", in_service, irq_active, pc_redirect);
    end
    tick();
  endtask

  task automatic test_nested();
    bit got; int n; logic [31:0] e;
    pc_id = 32'h20; irq = 3'b001; exp_q.push_back(32'h100);
    tick(); irq = '0;
    wait_redir(5, got, n);
    e = exp_q.pop_front();
    total++;
    if (!got || pc_target !== e) begin
      bad++; $display("FAIL nest_entry0: got=%0d t=%h want %h", got, pc_target, e);
    end
    tick();
    pc_id = 32'h105; irq = 3'b100; exp_q.push_back(32'h180);
    tick(); irq = '0;
    wait_redir(5, got, n);
    e = exp_q.pop_front();
    total++;
    if (!got || {flush, pc_target} !== {1'b1, e}) begin
      bad++; $display("FAIL nest_entry2: got=%0d f=%b t=%h want 1 %h", got, flush, pc_target, e);
    end
    tick();
    total++;
    if (irq_active !== 3'b101) begin
      bad++; $display("FAIL nest_active: got %b want 101", irq_active);
    end
    pc_id = 32'h190; eret_id = 1'b1; exp_q.push_back(32'h105);
    #1;
    e = exp_q.pop_front();
    total++;
    if ({pc_redirect, pc_target} !== {1'b1, e}) begin
      bad++; $display("FAIL nest_eret1: got r=%b t=%h want 1 %h", pc_redirect, pc_target, e);
    end
    tick();
    total++;
    if ({irq_active, in_service} !== {3'b001, 1'b1}) begin
      bad++; $display("FAIL nest_pop1: got a=%b s=%b want 001 1", irq_active, in_service);
    end
    pc_id = 32'h110; exp_q.push_back(32'h20);
    #1;
    e = exp_q.pop_front();
    total++;
    if ({pc_redirect, pc_target} !== {1'b1, e}) begin
      bad++; $display("FAIL nest_eret2: got r=%b t=%h want 1 %h", pc_redirect, pc_target, e);
    end
    tick(); eret_id = 1'b0;
    #1;
    total++;
    if ({irq_active, in_service} !== 4'b0) begin
      bad++; $display("FAIL nest_exit: got a=%b s=%b want 000 0", irq_active, in_service);
    end
    tick();
  endtask

  task automatic test_lower();
    bit got; int n; logic [31:0] e;
    pc_id = 32'h30; irq = 3'b010; exp_q.push_back(32'h140);
    tick(); irq = '0;
    wait_redir(5, got, n);
    e = exp_q.pop_front();
    total++;
    if (!got || pc_target !== e) begin
      bad++; $display("FAIL lower_entry1: got=%0d t=%h want %h", got, pc_target, e);
    end
    tick();
    pc_id = 32'h148; irq = 3'b001;
    tick(); irq = '0;
    wait_redir(4, got, n);
    total++;
    if (got || irq_pending !== 3'b001) begin
      bad++; $display("FAIL lower_blocked: redirect=%0d p=%b want 0 001", got, irq_pending);
    end
    pc_id = 32'h150; eret_id = 1'b1; exp_q.push_back(32'h30);
    #1;
    e = exp_q.pop_front();
    total++;
    if ({pc_redirect, pc_target} !== {1'b1, e}) begin
      bad++; $display("FAIL lower_eret: got r=%b t=%h want 1 %h", pc_redirect, pc_target, e);
    end
    tick();
    eret_id = 1'b0; pc_id = 32'h30; exp_q.push_back(32'h100);
    wait_redir(5, got, n);
    e = exp_q.pop_front();
    total++;
    if (!got || {pc_target, irq_active} !== {e, 3'b000}) begin
      bad++; $display("FAIL lower_entry0: got=%0d t=%h a=%b want %h 000", got, pc_target, irq_active, e);
    end
    tick();
    pc_id = 32'h108; eret_id = 1'b1; exp_q.push_back(32'h30);
    #1;
    e = exp_q.pop_front();
    total++;
    if ({pc_redirect, pc_target} !== {1'b1, e}) begin
      bad++; $display("FAIL lower_epc: got r=%b t=%h want 1 %h", pc_redirect, pc_target, e);
    end
    tick(); eret_id = 1'b0;
    tick();
  endtask

  task automatic test_stall();
    bit got; int n; logic [31:0] e;
    pc_id = 32'h44; irq = 3'b010; stall_id = 1'b1; exp_q.push_back(32'h140);
    tick(); irq = '0;
    tick();
    wait_redir(3, got, n);
    total++;
    if (got || flush !== 1'b0) begin
      bad++; $display("FAIL stall_hold: redirect=%0d f=%b want none", got, flush);
    end
    stall_id = 1'b0;
    wait_redir(1, got, n);
    e = exp_q.pop_front();
    total++;
    if (!got || {flush, pc_target} !== {1'b1, e}) begin
      bad++; $display("FAIL stall_release: got=%0d f=%b t=%h want 1 %h", got, flush, pc_target, e);
    end
    tick();
    pc_id = 32'h150; eret_id = 1'b1; exp_q.push_back(32'h44);
    #1;
    e = exp_q.pop_front();
    total++;
    if ({pc_redirect, pc_target} !== {1'b1, e}) begin
      bad++; $display("FAIL stall_eret: got r=%b t=%h want 1 %h", pc_redirect, pc_target, e);
    end
    tick(); eret_id = 1'b0;
    pc_id = 32'h60; irq = 3'b100; branch_ex = 1'b1; exp_q.push_back(32'h180);
    tick(); irq = '0;
    tick();
    wait_redir(2, got, n);
    total++;
    if (got) begin
      bad++; $display("FAIL branch_hold: redirect=%0d want 0", got);
    end
    branch_ex = 1'b0;
    wait_redir(1, got, n);
    e = exp_q.pop_front();
    total++;
    if (!got || pc_target !== e) begin
      bad++; $display("FAIL branch_release: got=%0d t=%h want %h", got, pc_target, e);
    end
    tick();
    pc_id = 32'h190; eret_id = 1'b1; exp_q.push_back(32'h60);
    #1;
    e = exp_q.pop_front();
    total++;
    if ({pc_redirect, pc_target} !== {1'b1, e}) begin
      bad++; $display("FAIL branch_eret: got r=%b t=%h want 1 %h", pc_redirect, pc_target, e);
    end
    tick(); eret_id = 1'b0;
    tick();
  endtask

  task automatic test_collision();
    bit got; int n; logic [31:0] e;
    pc_id = 32'h40; irq = 3'b001; stall_id = 1'b1; exp_q.push_back(32'h100);
    tick(); irq = '0;
    tick();
    stall_id = 1'b0; eret_id = 1'b1;
    wait_redir(1, got, n);
    e = exp_q.pop_front();
    total++;
    if (!got || pc_target !== e) begin
      bad++; $display("FAIL collide_entry: got=%0d t=%h want %h", got, pc_target, e);
    end
    tick(); eret_id = 1'b0;
    #1;
    total++;
    if ({irq_active, in_service, eret_err} !== {3'b001, 1'b1, 1'b0}) begin
      bad++; $display("FAIL collide_state: got a=%b s=%b e=%b want 001 1 0", irq_active, in_service, eret_err);
    end
    pc_id = 32'h104; eret_id = 1'b1; exp_q.push_back(32'h40);
    #1;
    e = exp_q.pop_front();
    total++;
    if ({pc_redirect, pc_target} !== {1'b1, e}) begin
      bad++; $display("FAIL collide_eret: got r=%b t=%h want 1 %h", pc_redirect, pc_target, e);
    end
    tick();
    pc_id = 32'h40;
    #1;
    total++;
    if ({flush, pc_redirect, pc_target} !== '0) begin
      bad++; $display("FAIL eret_depth0: got f=%b r=%b t=%h want 0 0 0", flush, pc_redirect, pc_target);
    end
    tick(); eret_id = 1'b0;
    tick(); tick();
    total++;
    if (eret_err !== 1'b1) begin
      bad++; $display("FAIL eret_err_sticky: got %b want 1", eret_err);
    end
  endtask

  task automatic test_halt_and_reset();
    bit got; int n; logic [31:0] e;
    halt = 1'b1; pc_id = 32'h70; irq = 3'b010; exp_q.push_back(32'h140);
    tick(); irq = '0;
    wait_redir(8, got, n);
    total++;
    if (got || irq_pending !== 3'b010) begin
      bad++; $display("FAIL halt_block: redirect=%0d p=%b want 0 010", got, irq_pending);
    end
    halt = 1'b0;
    wait_redir(5, got, n);
    e = exp_q.pop_front();
    total++;
    if (!got || pc_target !== e) begin
      bad++; $display("FAIL halt_release: got=%0d t=%h want %h", got, pc_target, e);
    end
    tick();
    rst = 1'b1; eret_id = 1'b1; pc_id = 32'h150;
    #1;
    total++;
    if ({flush, pc_redirect, pc_target} !== '0) begin
      bad++; $display("FAIL rst_outputs: got f=%b r=%b t=%h want 0 0 0", flush, pc_redirect, pc_target);
    end
    tick();
    rst = 1'b0; eret_id = 1'b0;
    #1;
    total++;
    if ({in_service, irq_active, irq_pending, eret_err, pc_redirect} !== '0) begin
      bad++; $display("FAIL rst_mid_service: got s=%b a=%b p=%b e=%b r=%b want all zero",
                      in_service, irq_active, irq_pending, eret_err, pc_redirect);
    end
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_nested();
    test_lower();
    test_stall();
    test_collision();
    test_halt_and_reset();
    total++;
    if (exp_q.size() != 0) begin
      bad++; $display("FAIL scoreboard_drain: %0d left want 0", exp_q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/int_controller.md
Name: int_controller

Overview:
- Vectored, nestable interrupt controller for the 5-stage pipeline; sequences entry to and exit from handlers.
- Latches external interrupt requests and waits for a safe point at the ID stage.
- On entry: kills the instruction in ID and saves its PC on an EPC stack, then redirects fetch to the handler vector.
- On ERET decoded in ID: pops the EPC stack and redirects fetch back.

Parameters:
NUM_IRQ, 3, number of interrupt sources; index NUM_IRQ-1 has the highest priority.
VEC_BASE, 32'h0000_0100, handler vector of source 0 (word-addressed PC).
VEC_STRIDE, 32'h0000_0040, word spacing between successive source vectors.

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous, active-high reset
irq  in  NUM_IRQ  level request lines, already synchronised; only a rising edge counts as a request
pc_id  in  32  PC of the instruction currently in ID
id_valid  in  1  ID holds a real (non-bubble) instruction
stall_id  in  1  ID is stalled (load-use or syscall conflict)
branch_ex  in  1  a jump/branch redirect is in progress this cycle
eret_id  in  1  instruction in ID decodes as ERET
halt  in  1  program halted; blocks new entries
flush  out  1  kill IF/ID and ID/EX contents this cycle
pc_redirect  out  1  load pc_target into PC this cycle
pc_target  out  32  handler vector or popped EPC
in_service  out  1  stack depth > 0
irq_active  out  NUM_IRQ  sources currently in service (nested set)
irq_pending  out  NUM_IRQ  latched requests not yet taken
eret_err  out  1  sticky; set by an ERET seen while depth == 0

Behaviour:
- Reset (sync, rst=1 at clk edge):
  - State = S_NORM; pending, active, depth, irq_d, eret_err = 0.
  - flush, pc_redirect = 0; pc_target = 0.
  - A reset mid-service discards the stack with no redirect.
- Edge capture:
  - irq_d <= irq.
  - pending[i] set on irq[i] & ~irq_d[i].
  - Cleared when source i is accepted; a set and a clear in the same cycle leave the bit set.
- cur_prio = (index of highest active bit)+1, or 0 when none is active.
- cand = highest pending index with index+1 > cur_prio; cand_ok when such an index exists and halt=0.
- safe = id_valid & ~stall_id & ~branch_ex.
- States:
  - S_NORM:
    - If cand_ok -> S_WAIT.
    - Else if eret_id & safe & depth>0: perform ERET this cycle (see below); stay in S_NORM.
    - ERET with depth==0 and safe: no redirect, eret_err <= 1.
  - S_WAIT:
    - If cand_ok drops (halt rises) -> S_NORM.
    - If safe, acceptance this cycle (combinational outputs): flush=1, pc_redirect=1, pc_target = VEC_BASE + cand*VEC_STRIDE.
    - At the edge: push pc_id; active[cand] <= 1; pending[cand] <= 0; depth++; -> S_NORM.
    - cand is re-evaluated every cycle while waiting, so a higher request arriving during S_WAIT wins.
    - An ERET in ID during acceptance is killed; its PC becomes the EPC, and it re-executes after return.
- ERET (combinational in the qualifying cycle):
  - flush=1, pc_redirect=1, pc_target = stack top.
  - At the edge: pop; clear the highest active bit; depth--.
- Latency:
  - Request edge to pending: 1 cycle.
  - Pending to acceptance: ≥1 cycle (S_NORM -> S_WAIT), then until safe.
- Stack:
  - Depth NUM_IRQ; overflow is impossible because strictly increasing priority bounds nesting.
  - A push when full is a design error; assertion only.
- Outputs flush, pc_redirect and pc_target are 0 in every cycle without acceptance or ERET.
- in_service = (depth != 0).

Decomposition:
- Shared package int_pkg: state encoding (S_NORM, S_WAIT), VEC_BASE/VEC_STRIDE defaults, NUM_IRQ default.
- Sub-module int_epc_stack (push/pop/top/depth, depth NUM_IRQ, width 32), reused by any later CP0-style block.
- Priority encoder stays inline.

Test Plan:
- Single irq[0] edge, ID safe, pc_id=0x20 -> acceptance 2 cycles later: flush=1, pc_redirect=1, pc_target=0x100, irq_active=001. ERET in ID -> pc_target=0x20, in_service=0.
- Nested: in irq[0] handler at pc_id=0x105, irq[2] edge -> pc_target=0x180 with EPC 0x105. First ERET -> 0x105, active=001. Second ERET -> original EPC.
- Lower while higher active: in irq[1] service, irq[0] edge -> pending=001, no entry. ERET -> return; irq[0] accepted next safe cycle with EPC = returned PC.
- Stall gating: irq[1] pending, stall_id=1 for 3 cycles then 0 -> no flush while stalled; acceptance in the first cycle stall_id=0. branch_ex=1 delays acceptance likewise.
- ERET vs irq collision: S_WAIT, eret_id=1, pc_id=0x40 -> interrupt taken, EPC=0x40, no pop. Later ERET -> PC=0x40 and the ERET re-executes.
- Edge cases:
  - ERET with depth 0 -> no redirect, eret_err=1 (sticky).
  - halt=1 with pending -> never accepted.
  - rst mid-service -> all outputs 0, depth 0 next cycle.
